// File: rtl/spi_rx_deser.sv
// rtl/spi_rx_deser.sv - SPI mode-0 responder: synchronised pins, byte deserialiser, {dc,byte} FWFT FIFO
// Optional statistics counters are built when SPI_RX_STATS_EN is defined.
module spi_rx_deser #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          spi_sk,
    input  logic                          spi_cs_n,
    input  logic                          spi_mosi,
    input  logic                          spi_dc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_data,
    output logic                          out_dc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          err_clr,
    output logic [15:0]                   byte_count,
    output logic [7:0]                    err_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] dc_sync_q;
    logic [SYNC_STAGES-1:0] settle_q;
    logic                   sk_d_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sk_sync_q   <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            dc_sync_q   <= '0;
            settle_q    <= '0;
            sk_d_q      <= 1'b0;
        end else begin
            sk_sync_q   <= {sk_sync_q[SYNC_STAGES-2:0], spi_sk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], spi_dc};
            settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
            sk_d_q      <= sk_sync_q[SYNC_STAGES-1];
        end
    end

    logic sk_s, cs_s, mosi_s, dc_s, settled, sk_rise;
    assign sk_s    = sk_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign dc_s    = dc_sync_q[SYNC_STAGES-1];
    assign settled = settle_q[SYNC_STAGES-1];
    assign sk_rise = sk_s & ~sk_d_q;

    state_t     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [6:0] shift_q, shift_d;
    logic [8:0] word_q, word_d;
    logic       push_q, push_d;
    logic       armed_q, armed_d;
    logic       frame_err_q, frame_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            word_q      <= '0;
            push_q      <= 1'b0;
            armed_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            word_q      <= word_d;
            push_q      <= push_d;
            armed_q     <= armed_d;
            frame_err_q <= frame_err_d;
        end
    end

    // armed_q only rises once the synchronisers hold real pin values and CS is
    // seen high, so a CS already low at reset release never starts a frame.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        word_d      = word_q;
        push_d      = 1'b0;
        armed_d     = armed_q;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                bitcnt_d = '0;
                if (settled && cs_s) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !cs_s) begin
                    armed_d = 1'b0;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (cs_s) begin
                    frame_err_d = (bitcnt_q != 3'd0);
                    bitcnt_d    = '0;
                    state_d     = IDLE;
                end else if (sk_rise) begin
                    shift_d = {shift_q[5:0], mosi_s};
                    if (bitcnt_q == 3'd7) begin
                        word_d   = {dc_s, shift_q, mosi_s};
                        push_d   = 1'b1;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          overflow_q;
    logic          full, do_push, do_pop, drop;
    logic [8:0]    head;

    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign do_pop  = (level_q != '0) && out_ready;
    assign do_push = push_q && (!full || do_pop);
    assign drop    = push_q && full && !do_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (err_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= word_q;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign out_valid  = (level_q != '0);
    assign out_data   = out_valid ? head[7:0] : 8'h00;
    assign out_dc     = out_valid ? head[8] : 1'b0;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

`ifdef SPI_RX_STATS_EN
    logic [15:0] byte_count_q;
    logic [7:0]  err_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            if (do_push) byte_count_q <= byte_count_q + 16'd1;
            if ((frame_err_q || drop) && err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign byte_count = byte_count_q;
    assign err_count  = err_count_q;
`else
    assign byte_count = '0;
    assign err_count  = '0;
`endif

endmodule

// File: tb/tb_spi_rx_deser.sv
// tb/tb_spi_rx_deser.sv - directed self-checking bench for spi_rx_deser
module tb_spi_rx_deser;

    localparam int FIFO_DEPTH  = 16;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_dc = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_dc;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        frame_err;
    logic        err_clr = 1'b0;
    logic [15:0] byte_count;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_fail = 0;
    int fe_cnt = 0;
    logic [8:0] beats[$];

    spi_rx_deser #(.FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .reset(reset), .spi_sk(spi_sk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_dc(spi_dc), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_dc(out_dc),
        .fifo_level(fifo_level), .overflow(overflow), .frame_err(frame_err),
        .err_clr(err_clr), .byte_count(byte_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so values seen at negedge are what the next posedge uses.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) beats.push_back({out_dc, out_data});
        if (!reset && frame_err) fe_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b, input logic dc);
        spi_mosi = b;
        spi_dc   = dc;
        repeat (HALF) tick();
        spi_sk = 1'b1;
        repeat (HALF) tick();
        spi_sk = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] b, input logic dc, input int n);
        for (int i = 7; i > 7 - n; i--) spi_bit(b[i], dc);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        repeat (HALF) tick();
    endtask

    task automatic cs_high();
        repeat (HALF) tick();
        spi_cs_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
        beats.delete();
        fe_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %0h want 00", out_data); end
        n_cmp++; if (out_dc !== 1'b0) begin n_fail++; $display("FAIL reset_out_dc: got %0b want 0", out_dc); end
        n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %0b want 0", frame_err); end
        n_cmp++; if (byte_count !== 16'd0) begin n_fail++; $display("FAIL reset_byte_count: got %0d want 0", byte_count); end
        n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        reset = 1'b0;
        repeat (10) tick();
        beats.delete();
        fe_cnt = 0;
    endtask

    task automatic test_byte_delivery();
        int lat;
        out_ready = 1'b1;
        cs_low();
        spi_bits(8'hA5, 1'b0, 7);
        spi_mosi = 1'b1;
        repeat (HALF) tick();
        spi_sk = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        n_cmp++; if (lat !== SYNC_STAGES + 2) begin n_fail++; $display("FAIL byte_latency: got %0d want %0d", lat, SYNC_STAGES + 2); end
        repeat (HALF) tick();
        spi_sk = 1'b0;
        cs_high();
        n_cmp++; if (beats.size() !== 1) begin n_fail++; $display("FAIL byte_beats: got %0d want 1", beats.size()); end
        if (beats.size() > 0) begin
            n_cmp++; if (beats[0] !== 9'h0A5) begin n_fail++; $display("FAIL byte_value: got %0h want 0a5", beats[0]); end
        end
        n_cmp++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL byte_frame_err: got %0d want 0", fe_cnt); end
        beats.delete();
    endtask

    task automatic test_dc_per_byte();
        logic [8:0] exp [3];
        exp[0] = 9'h015; exp[1] = 9'h100; exp[2] = 9'h15F;
        cs_low();
        for (int i = 0; i < 3; i++) spi_bits(exp[i][7:0], exp[i][8], 8);
        cs_high();
        n_cmp++; if (beats.size() !== 3) begin n_fail++; $display("FAIL dc_beats: got %0d want 3", beats.size()); end
        for (int i = 0; i < 3; i++) begin
            if (beats.size() > 0) begin
                n_cmp++; if (beats[0] !== exp[i]) begin n_fail++; $display("FAIL dc_beat%0d: got %0h want %0h", i, beats[0], exp[i]); end
                void'(beats.pop_front());
            end
        end
        beats.delete();
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        cs_low();
        for (int i = 0; i < 17; i++) spi_bits(8'(i), 1'b1, 8);
        cs_high();
        n_cmp++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL ovf_level: got %0d want 16", fifo_level); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
        n_cmp++; if ({out_dc, out_data} !== 9'h100) begin n_fail++; $display("FAIL ovf_head: got %0h want 100", {out_dc, out_data}); end
`ifdef SPI_RX_STATS_EN
        n_cmp++; if (byte_count !== 16'd16) begin n_fail++; $display("FAIL ovf_byte_count: got %0d want 16", byte_count); end
        n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL ovf_err_count: got %0d want 1", err_count); end
`else
        n_cmp++; if (byte_count !== 16'd0) begin n_fail++; $display("FAIL ovf_byte_count: got %0d want 0", byte_count); end
        n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL ovf_err_count: got %0d want 0", err_count); end
`endif
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b want 0", overflow); end
        out_ready = 1'b1;
        repeat (24) tick();
        n_cmp++; if (beats.size() !== 16) begin n_fail++; $display("FAIL ovf_beats: got %0d want 16", beats.size()); end
        for (int i = 0; i < 16; i++) begin
            if (beats.size() > 0) begin
                n_cmp++; if (beats[0] !== {1'b1, 8'(i)}) begin n_fail++; $display("FAIL ovf_beat%0d: got %0h want %0h", i, beats[0], {1'b1, 8'(i)}); end
                void'(beats.pop_front());
            end
        end
        n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL ovf_drained: got %0d want 0", fifo_level); end
        beats.delete();
    endtask

    task automatic test_partial_byte();
        fe_cnt = 0;
        cs_low();
        spi_bits(8'hFF, 1'b1, 5);
        cs_high();
        cs_low();
        spi_bits(8'h3C, 1'b0, 8);
        cs_high();
        n_cmp++; if (fe_cnt !== 1) begin n_fail++; $display("FAIL partial_frame_err: got %0d want 1", fe_cnt); end
        n_cmp++; if (beats.size() !== 1) begin n_fail++; $display("FAIL partial_beats: got %0d want 1", beats.size()); end
        if (beats.size() > 0) begin
            n_cmp++; if (beats[0] !== 9'h03C) begin n_fail++; $display("FAIL partial_value: got %0h want 03c", beats[0]); end
        end
`ifdef SPI_RX_STATS_EN
        n_cmp++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL partial_err_count: got %0d want 2", err_count); end
`endif
        beats.delete();
    endtask

    task automatic test_full_read_write();
        do_reset();
        out_ready = 1'b0;
        cs_low();
        for (int i = 0; i < 16; i++) spi_bits(8'h40 + 8'(i), 1'b0, 8);
        n_cmp++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL rw_fill_level: got %0d want 16", fifo_level); end
        spi_bits(8'h50, 1'b0, 7);
        spi_mosi = 1'b0;
        repeat (HALF) tick();
        spi_sk = 1'b1;
        repeat (SYNC_STAGES + 1) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL rw_level: got %0d want 16", fifo_level); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rw_overflow: got %0b want 0", overflow); end
        repeat (HALF) tick();
        spi_sk = 1'b0;
        cs_high();
        out_ready = 1'b1;
        repeat (24) tick();
        n_cmp++; if (beats.size() !== 17) begin n_fail++; $display("FAIL rw_beats: got %0d want 17", beats.size()); end
        for (int i = 0; i < 17; i++) begin
            if (beats.size() > 0) begin
                n_cmp++; if (beats[0] !== {1'b0, 8'h40 + 8'(i)}) begin n_fail++; $display("FAIL rw_beat%0d: got %0h want %0h", i, beats[0], {1'b0, 8'h40 + 8'(i)}); end
                void'(beats.pop_front());
            end
        end
        beats.delete();
    endtask

    task automatic test_reset_mid_byte();
        out_ready = 1'b0;
        cs_low();
        spi_bits(8'h77, 1'b0, 8);
        repeat (8) tick();
        spi_bits(8'hF0, 1'b0, 4);
        reset = 1'b1;
        repeat (2) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL mid_level: got %0d want 0", fifo_level); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL mid_out_data: got %0h want 00", out_data); end
        n_cmp++; if (byte_count !== 16'd0) begin n_fail++; $display("FAIL mid_byte_count: got %0d want 0", byte_count); end
        reset = 1'b0;
        out_ready = 1'b1;
        beats.delete();
        fe_cnt = 0;
        spi_bits(8'h0F, 1'b0, 8);
        cs_high();
        cs_low();
        spi_bits(8'h81, 1'b0, 8);
        cs_high();
        n_cmp++; if (beats.size() !== 1) begin n_fail++; $display("FAIL mid_beats: got %0d want 1", beats.size()); end
        if (beats.size() > 0) begin
            n_cmp++; if (beats[0] !== 9'h081) begin n_fail++; $display("FAIL mid_value: got %0h want 081", beats[0]); end
        end
        n_cmp++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL mid_frame_err: got %0d want 0", fe_cnt); end
        beats.delete();
    endtask

    initial begin
        test_reset();
        test_byte_delivery();
        test_dc_per_byte();
        test_overflow();
        test_partial_byte();
        test_full_read_write();
        test_reset_mid_byte();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
